// File: rtl/priority_encoder_arbiter.sv
// Round-robin arbiter that shares one priority_encoder among N_REQ requesters.
// Each issued request is tagged with its requester ID and comes back with the encoder result.
module priority_encoder_arbiter #(
  parameter int WIDTH        = 5,
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ*WIDTH-1:0]   req_data_i,
  input  logic [N_REQ-1:0]         req_val_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [WIDTH-1:0]         enc_data_o,
  output logic                     enc_val_o,
  input  logic [WIDTH-1:0]         enc_left_i,
  input  logic [WIDTH-1:0]         enc_right_i,
  input  logic                     enc_val_i,
  output logic [WIDTH-1:0]         resp_left_o,
  output logic [WIDTH-1:0]         resp_right_o,
  output logic [$clog2(N_REQ)-1:0] resp_id_o,
  output logic                     resp_val_o,
  output logic                     err_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int AW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_INFLIGHT);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [AW-1:0]    LAST_SLOT = AW'(MAX_INFLIGHT - 1);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [ID_W-1:0]  idFifo_q [MAX_INFLIGHT];

  logic [WIDTH-1:0] encData_q;
  logic             encVal_q;
  logic [WIDTH-1:0] respLeft_q, respRight_q;
  logic [ID_W-1:0]  respId_q;
  logic             respVal_q;
  logic             err_q;

  logic [WIDTH-1:0] reqData [N_REQ];
  logic [ID_W:0]    scanIdx;
  logic [ID_W-1:0]  grantIdx;
  logic             xfer;
  logic             canIssue;
  logic             fifoEmpty;
  logic             pop;

  assign canIssue  = (count_q < MAX_CNT);
  assign fifoEmpty = (count_q == '0);
  assign pop       = enc_val_i && !fifoEmpty;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      reqData[k] = req_data_i[k*WIDTH +: WIDTH];
    end
  end

  // Scan channels starting at the pointer; the first valid one wins if a slot is free.
  always_comb begin
    req_ready_o = '0;
    grantIdx    = '0;
    xfer        = 1'b0;
    scanIdx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scanIdx = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (scanIdx >= (ID_W+1)'(N_REQ)) begin
        scanIdx = scanIdx - (ID_W+1)'(N_REQ);
      end
      if (canIssue && !xfer && req_val_i[scanIdx[ID_W-1:0]]) begin
        xfer     = 1'b1;
        grantIdx = scanIdx[ID_W-1:0];
      end
    end
    if (xfer) begin
      req_ready_o[grantIdx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (xfer) begin
      ptr_d = (grantIdx == LAST_ID) ? '0 : grantIdx + 1'b1;
    end
    case ({xfer, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      count_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      encData_q   <= '0;
      encVal_q    <= 1'b0;
      respLeft_q  <= '0;
      respRight_q <= '0;
      respId_q    <= '0;
      respVal_q   <= 1'b0;
      err_q       <= 1'b0;
      for (int s = 0; s < MAX_INFLIGHT; s++) begin
        idFifo_q[s] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      encVal_q  <= xfer;
      respVal_q <= pop;
      if (xfer) begin
        encData_q          <= reqData[grantIdx];
        idFifo_q[wrPtr_q]  <= grantIdx;
        wrPtr_q            <= (wrPtr_q == LAST_SLOT) ? '0 : wrPtr_q + 1'b1;
      end
      // Results only pair with IDs still queued; an orphan result is flagged instead.
      if (pop) begin
        respLeft_q  <= enc_left_i;
        respRight_q <= enc_right_i;
        respId_q    <= idFifo_q[rdPtr_q];
        rdPtr_q     <= (rdPtr_q == LAST_SLOT) ? '0 : rdPtr_q + 1'b1;
      end
      if (enc_val_i && fifoEmpty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign enc_data_o   = encData_q;
  assign enc_val_o    = encVal_q;
  assign resp_left_o  = respLeft_q;
  assign resp_right_o = respRight_q;
  assign resp_id_o    = respId_q;
  assign resp_val_o   = respVal_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_priority_encoder_arbiter.sv
// Bench for priority_encoder_arbiter: a queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_priority_encoder_arbiter;

  localparam int WIDTH        = 5;
  localparam int N_REQ        = 4;
  localparam int MAX_INFLIGHT = 4;
  localparam int ID_W         = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [N_REQ*WIDTH-1:0] req_data_i = {5'b11000, 5'b01100, 5'b00110, 5'b10011};
  logic [N_REQ-1:0]       req_val_i = '0;
  logic [N_REQ-1:0]       req_ready_o;
  logic [WIDTH-1:0]       enc_data_o;
  logic                   enc_val_o;
  logic [WIDTH-1:0]       enc_left_i = '0;
  logic [WIDTH-1:0]       enc_right_i = '0;
  logic                   enc_val_i = 1'b0;
  logic [WIDTH-1:0]       resp_left_o;
  logic [WIDTH-1:0]       resp_right_o;
  logic [ID_W-1:0]        resp_id_o;
  logic                   resp_val_o;
  logic                   err_o;

  int checks   = 0;
  int failures = 0;
  logic autoEnc = 1'b0;

  priority_encoder_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_data_i(req_data_i), .req_val_i(req_val_i), .req_ready_o(req_ready_o),
    .enc_data_o(enc_data_o), .enc_val_o(enc_val_o),
    .enc_left_i(enc_left_i), .enc_right_i(enc_right_i), .enc_val_i(enc_val_i),
    .resp_left_o(resp_left_o), .resp_right_o(resp_right_o), .resp_id_o(resp_id_o),
    .resp_val_o(resp_val_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Model state: a pointer, a queue of outstanding IDs, and the expected registered outputs.
  int               mPtr = 0;
  int               idQ[$];
  logic             mEncVal = 1'b0;
  logic [WIDTH-1:0] mEncData = '0;
  logic             mRespVal = 1'b0;
  logic [WIDTH-1:0] mRespLeft = '0;
  logic [WIDTH-1:0] mRespRight = '0;
  int               mRespId = 0;
  logic             mErr = 1'b0;

  function automatic int modelGrant();
    if (idQ.size() >= MAX_INFLIGHT) return -1;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_val_i[(mPtr + i) % N_REQ]) return (mPtr + i) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] modelReady();
    logic [N_REQ-1:0] r;
    int g;
    r = '0;
    g = modelGrant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] msbOnly(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      if (x[b]) begin
        r[b] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] lsbOnly(input logic [WIDTH-1:0] x);
    return x & (~x + 1'b1);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mPtr = 0; idQ.delete(); mEncVal = 0; mEncData = '0;
        mRespVal = 0; mRespLeft = '0; mRespRight = '0; mRespId = 0; mErr = 0;
      end else begin
        int g;
        g = modelGrant();
        mRespVal = 1'b0;
        if (enc_val_i) begin
          if (idQ.size() > 0) begin
            mRespId    = idQ.pop_front();
            mRespVal   = 1'b1;
            mRespLeft  = enc_left_i;
            mRespRight = enc_right_i;
          end else begin
            mErr = 1'b1;
          end
        end
        mEncVal = (g >= 0);
        if (g >= 0) begin
          mEncData = req_data_i[g*WIDTH +: WIDTH];
          idQ.push_back(g);
          mPtr = (g + 1) % N_REQ;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("m_ready",     32'(req_ready_o),  32'(modelReady()));
      checkOutput("m_enc_val",   32'(enc_val_o),    32'(mEncVal));
      checkOutput("m_enc_data",  32'(enc_data_o),   32'(mEncData));
      checkOutput("m_resp_val",  32'(resp_val_o),   32'(mRespVal));
      checkOutput("m_resp_id",   32'(resp_id_o),    32'(mRespId));
      checkOutput("m_resp_left", 32'(resp_left_o),  32'(mRespLeft));
      checkOutput("m_resp_right",32'(resp_right_o), 32'(mRespRight));
      checkOutput("m_err",       32'(err_o),        32'(mErr));
    end
  end

  // Drives one cycle of inputs shortly after the rising edge; in auto mode the bench acts as a zero-latency encoder.
  task automatic applyStimulus(input logic [N_REQ-1:0] val, input logic ev,
                               input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    @(posedge clk);
    #2;
    req_val_i = val;
    if (autoEnc) begin
      enc_val_i   = enc_val_o;
      enc_left_i  = msbOnly(enc_data_o);
      enc_right_i = lsbOnly(enc_data_o);
    end else begin
      enc_val_i   = ev;
      enc_left_i  = l;
      enc_right_i = r;
    end
  endtask

  initial begin
    int nXfer;
    int fairExp;
    int skipExp[3] = '{3, 1, 3};
    int drainExp[4] = '{0, 0, 2, 1};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_enc_val",  32'(enc_val_o),  32'd0);
    checkOutput("rst_resp_val", 32'(resp_val_o), 32'd0);
    checkOutput("rst_err",      32'(err_o),      32'd0);

    // Single request on channel 2, encoder answering two cycles after issue.
    applyStimulus(4'b0100, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("single_ready", 32'(req_ready_o), 32'h4);
    applyStimulus(4'b0000, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("single_enc_val",  32'(enc_val_o),  32'd1);
    checkOutput("single_enc_data", 32'(enc_data_o), 32'b01100);
    applyStimulus(4'b0000, 1'b0, '0, '0);
    applyStimulus(4'b0000, 1'b1, 5'b01000, 5'b00100);
    applyStimulus(4'b0000, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("single_resp_val",   32'(resp_val_o),   32'd1);
    checkOutput("single_resp_id",    32'(resp_id_o),    32'd2);
    checkOutput("single_resp_left",  32'(resp_left_o),  32'b01000);
    checkOutput("single_resp_right", 32'(resp_right_o), 32'b00100);

    // Fairness with every channel requesting; channel 3 first so the scan starts at 0.
    autoEnc = 1'b1;
    applyStimulus(4'b1000, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, 1'b0, '0, '0);
      @(negedge clk);
      fairExp = i % 4;
      checkOutput("fair_grant", 32'(req_ready_o), 32'(1 << fairExp));
    end

    applyStimulus(4'b0010, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("skip_setup", 32'(req_ready_o), 32'h2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1010, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("skip_grant", 32'(req_ready_o), 32'(1 << skipExp[i]));
    end
    applyStimulus(4'b0000, 1'b0, '0, '0);
    applyStimulus(4'b0000, 1'b0, '0, '0);
    autoEnc = 1'b0;

    // Encoder stalled: only MAX_INFLIGHT transfers fit.
    nXfer = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0001, 1'b0, '0, '0);
      @(negedge clk);
      if (req_ready_o[0]) nXfer++;
    end
    checkOutput("throttle_xfers", 32'(nXfer), 32'd4);
    checkOutput("throttle_ready", 32'(req_ready_o), 32'h0);
    applyStimulus(4'b0001, 1'b1, 5'b10000, 5'b00001);
    @(negedge clk);
    checkOutput("throttle_pop_noissue", 32'(req_ready_o), 32'h0);
    applyStimulus(4'b0001, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("throttle_refill", 32'(req_ready_o), 32'h1);
    applyStimulus(4'b0001, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("throttle_full_again", 32'(req_ready_o), 32'h0);

    // Simultaneous push and pop at three outstanding.
    applyStimulus(4'b0000, 1'b1, 5'b00010, 5'b00010);
    applyStimulus(4'b0100, 1'b1, 5'b00100, 5'b00001);
    @(negedge clk);
    checkOutput("pushpop_ready", 32'(req_ready_o), 32'h4);
    applyStimulus(4'b0010, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("pushpop_count3", 32'(req_ready_o), 32'h2);
    applyStimulus(4'b0010, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("pushpop_full", 32'(req_ready_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b1, 5'b10000, 5'b00010);
      applyStimulus(4'b0000, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("drain_val", 32'(resp_val_o), 32'd1);
      checkOutput("drain_id",  32'(resp_id_o),  32'(drainExp[i]));
    end

    // Reset with requests in flight, then an orphan encoder result.
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b0, '0, '0);
    @(posedge clk);
    #3 rst = 1'b1;
    req_val_i = '0;
    #1;
    checkOutput("midrst_enc_val",   32'(enc_val_o),    32'd0);
    checkOutput("midrst_enc_data",  32'(enc_data_o),   32'd0);
    checkOutput("midrst_resp_val",  32'(resp_val_o),   32'd0);
    checkOutput("midrst_resp_id",   32'(resp_id_o),    32'd0);
    checkOutput("midrst_resp_left", 32'(resp_left_o),  32'd0);
    checkOutput("midrst_err",       32'(err_o),        32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    applyStimulus(4'b0000, 1'b1, 5'b00100, 5'b00100);
    applyStimulus(4'b1111, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("postrst_ptr0",     32'(req_ready_o), 32'h1);
    checkOutput("postrst_err",      32'(err_o),       32'd1);
    checkOutput("postrst_resp_val", 32'(resp_val_o),  32'd0);
    applyStimulus(4'b0000, 1'b0, '0, '0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
